imm_ext_arbiter: RTL and testbench

Two-requester arbiter that time-shares the single 16-to-32-bit immediate extender between the decode stage (requester 0) and the branch-target unit (requester 1). It latches the winning requester's immediate and sign/zero-extend select, drives the shared extender, and registers the 32-bit result. It then returns the result to the winner with a one-cycle valid/acknowledge pulse. The block sits between the two requesters and the extender instance. The extender itself stays purely combinational and is instantiated outside this block.

---
 rtl/imm_ext_arbiter.sv | 77 +++++++
 tb/tb_imm_ext_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: time-shares one 16->32-bit immediate extender between two requesters.
// Define IMM_EXT_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module imm_ext_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [15:0] imm0_i,
  input  logic [15:0] imm1_i,
  input  logic        sext0_i,
  input  logic        sext1_i,
  input  logic [31:0] ext_out_i,
  output logic [15:0] ext_imm_o,
  output logic        ext_sext_o,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] resp_data_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, EXT, RESP} state_e;
  state_e      state_q, state_d;
  logic [15:0] imm_q, imm_d;
  logic        sext_q, sext_d;
  logic        win_q, win_d;
  logic [31:0] resp_q, resp_d;
  logic        win;
  logic        grant;
  assign grant = (state_q == IDLE) && (req0_i || req1_i);
`ifdef IMM_EXT_ARB_RR_EN
  logic last_q;
  // Requester 1 wins contention only if requester 0 was granted last.
  assign win = req1_i && (!req0_i || !last_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else if (grant) last_q <= win;
`else
  assign win = req1_i && !req0_i;
`endif
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    sext_d  = sext_q;
    win_d   = win_q;
    resp_d  = resp_q;
    if (grant) begin
      state_d = EXT;
      imm_d   = win ? imm1_i : imm0_i;
      sext_d  = win ? sext1_i : sext0_i;
      win_d   = win;
    end else if (state_q == EXT) begin
      state_d = RESP;
      resp_d  = ext_out_i;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      imm_q   <= '0;
      sext_q  <= 1'b0;
      win_q   <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      sext_q  <= sext_d;
      win_q   <= win_d;
      resp_q  <= resp_d;
    end
  assign ext_imm_o   = imm_q;
  assign ext_sext_o  = sext_q;
  assign resp_data_o = resp_q;
  assign ack0_o      = (state_q == RESP) && !win_q;
  assign ack1_o      = (state_q == RESP) && win_q;
  assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed and randomized transactions against a transaction-level model.
module tb_imm_ext_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, sext0 = 1'b0, sext1 = 1'b0;
  logic [15:0] imm0 = '0, imm1 = '0;
  logic [31:0] ext_out;
  logic [15:0] ext_imm;
  logic        ext_sext, ack0, ack1, busy;
  logic [31:0] resp_data;
  int          pass_n = 0, tot_n = 0;
  int          last_g = 1;

  always #5 clk = ~clk;

  assign ext_out = ext_sext ? {{16{ext_imm[15]}}, ext_imm} : {16'h0, ext_imm};

  imm_ext_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req0_i(req0), .req1_i(req1),
    .imm0_i(imm0), .imm1_i(imm1), .sext0_i(sext0), .sext1_i(sext1),
    .ext_out_i(ext_out), .ext_imm_o(ext_imm), .ext_sext_o(ext_sext),
    .ack0_o(ack0), .ack1_o(ack1), .resp_data_o(resp_data), .busy_o(busy)
  );

  function automatic logic [31:0] extv(input logic [15:0] v, input logic s);
    return (s && v >= 16'h8000) ? 32'(v) + 32'hFFFF0000 : 32'(v);
  endfunction

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef IMM_EXT_ARB_RR_EN
      return last_g == 1 ? 0 : 1;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  // One transaction starting in an IDLE cycle; reqs are driven for the sampling edge.
  task automatic txn(input logic r0, input logic r1, input logic [15:0] i0, input logic [15:0] i1,
                     input logic s0, input logic s1, input bit drop_mid, input string nm);
    int w;
    logic [15:0] wi;
    logic [31:0] e, prev;
    prev = resp_data;
    req0 = r0; req1 = r1; imm0 = i0; imm1 = i1; sext0 = s0; sext1 = s1;
    if (!r0 && !r1) begin
      @(posedge clk); #1;
      tot_n++;
      if ({busy, ack0, ack1, resp_data} !== {3'b000, prev})
        $display("FAIL %s idle: busy/ack0/ack1/resp=%b%b%b/%h want 000/%h", nm, busy, ack0, ack1, resp_data, prev);
      else pass_n++;
      return;
    end
    w = pick(r0, r1);
    last_g = w;
    wi = w ? i1 : i0;
    e = extv(wi, w ? s1 : s0);
    @(posedge clk); #1;
    tot_n++;
    if ({busy, ack0, ack1, ext_imm, ext_sext} !== {3'b100, wi, (w ? s1 : s0)})
      $display("FAIL %s ext: busy/ack0/ack1=%b%b%b ext_imm=%h sext=%b want 100 %h %b",
               nm, busy, ack0, ack1, ext_imm, ext_sext, wi, (w ? s1 : s0));
    else pass_n++;
    if (drop_mid) begin req0 = 1'b0; req1 = 1'b0; end
    @(posedge clk); #1;
    tot_n++;
    if ({busy, ack0, ack1, resp_data} !== {1'b1, w == 0, w == 1, e})
      $display("FAIL %s resp: busy/ack0/ack1=%b%b%b resp=%h want 1%b%b %h",
               nm, busy, ack0, ack1, resp_data, w == 0, w == 1, e);
    else pass_n++;
    @(posedge clk); #1;
    tot_n++;
    if ({busy, ack0, ack1, resp_data} !== {3'b000, e})
      $display("FAIL %s hold: busy/ack0/ack1=%b%b%b resp=%h want 000 %h", nm, busy, ack0, ack1, resp_data, e);
    else pass_n++;
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    tot_n++;
    if ({ack0, ack1, busy, resp_data, ext_imm, ext_sext} !== 52'h0)
      $display("FAIL reset_values: ack0=%b ack1=%b busy=%b resp=%h ext_imm=%h sext=%b want all 0",
               ack0, ack1, busy, resp_data, ext_imm, ext_sext);
    else pass_n++;
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    last_g = 1;
    @(posedge clk); #1;
    tot_n++;
    if ({ack0, ack1, busy} !== 3'b000) $display("FAIL reset_release: ack0/ack1/busy=%b%b%b want 000", ack0, ack1, busy);
    else pass_n++;
  endtask

  task automatic test_extend();
    txn(1, 0, 16'h8001, 16'h0, 1, 0, 0, "sext0_8001");
    txn(0, 1, 16'h0, 16'h8001, 0, 0, 0, "zext1_8001");
    txn(0, 1, 16'h0, 16'h7FFF, 0, 1, 0, "sext1_7fff");
    txn(1, 0, 16'hFFFF, 16'h0, 0, 0, 0, "zext0_ffff");
  endtask

  task automatic test_withdraw();
    req0 = 1'b1; imm0 = 16'h5555;
    #2 req0 = 1'b0;
    @(posedge clk); #1;
    tot_n++;
    if ({busy, ack0, ack1} !== 3'b000) $display("FAIL withdraw_before: busy/ack0/ack1=%b%b%b want 000", busy, ack0, ack1);
    else pass_n++;
    txn(0, 1, 16'h0, 16'hC3C3, 0, 1, 1, "withdraw_after");
  endtask

  task automatic test_contention();
    txn(1, 1, 16'hFFFF, 16'h1234, 1, 0, 0, "cont_a");
    txn(0, 1, 16'hFFFF, 16'h1234, 1, 0, 0, "cont_b");
    txn(1, 0, 16'hFFFF, 16'h1234, 1, 0, 0, "cont_c");
    txn(0, 1, 16'hFFFF, 16'h1234, 1, 0, 0, "cont_d");
    for (int i = 0; i < 4; i++) txn(1, 1, 16'hFFFF, 16'h1234, 1, 0, 0, "cont_held");
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; req1 = 1'b0; imm0 = 16'hABCD; sext0 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    tot_n++;
    if ({busy, ack0, ack1, resp_data, ext_imm} !== 51'h0)
      $display("FAIL reset_mid_clear: busy=%b ack0=%b ack1=%b resp=%h ext_imm=%h want 0", busy, ack0, ack1, resp_data, ext_imm);
    else pass_n++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tot_n++;
      if ({busy, ack0, ack1} !== 3'b000) $display("FAIL reset_mid_noack: busy/ack0/ack1=%b%b%b want 000", busy, ack0, ack1);
      else pass_n++;
    end
    #2 rst_n = 1'b1;
    last_g = 1;
    @(posedge clk); #1;
    tot_n++;
    if ({busy, ack0, ack1} !== 3'b000) $display("FAIL reset_mid_after: busy/ack0/ack1=%b%b%b want 000", busy, ack0, ack1);
    else pass_n++;
    txn(1, 1, 16'h0042, 16'h9999, 0, 1, 0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 7) == 0), "random");
  endtask

  initial begin
    test_reset();
    test_extend();
    test_withdraw();
    test_contention();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

  always @(negedge clk) begin
    tot_n++;
    if (ack0 && ack1) $display("FAIL ack_exclusive: ack0=%b ack1=%b want not both", ack0, ack1);
    else pass_n++;
  end
endmodule
